seg7_hc595_driver: RTL



---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_hc595_driver_if.sv | 21 ++
 rtl/seg7_hc595_driver_bin2bcd_seq.sv | 57 +++++
 rtl/seg7_hc595_driver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7 display driver shared definitions:
// segment patterns, BCD decode, scanner states.
package seg7_pkg;

  // active-low, bit7..0 = a,b,c,d,e,f,g,dp
  localparam logic [7:0] SEG_0 = 8'b0000_0011;
  localparam logic [7:0] SEG_1 = 8'b1001_1111;
  localparam logic [7:0] SEG_2 = 8'b0010_0101;
  localparam logic [7:0] SEG_3 = 8'b0000_1101;
  localparam logic [7:0] SEG_4 = 8'b1001_1001;
  localparam logic [7:0] SEG_5 = 8'b0100_1001;
  localparam logic [7:0] SEG_6 = 8'b0100_0001;
  localparam logic [7:0] SEG_7 = 8'b0001_1111;
  localparam logic [7:0] SEG_8 = 8'b0000_0001;
  localparam logic [7:0] SEG_9 = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    WAIT,
    LOAD,
    SHIFT,
    LATCH
  } scan_state_t;

  function automatic logic [7:0] decode(
    input logic [3:0] nib
  );
    logic [7:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_hc595_driver_if.sv
// Sample handshake into the seg7 display driver.
// value_i/value_valid from producer, value_ready back.
interface seg7_hc595_driver_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] value_i;
  logic              value_valid;
  logic              value_ready;

  modport master (
    output value_i,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_i,
    input  value_valid,
    output value_ready
  );
endinterface

// File: rtl/seg7_hc595_driver_bin2bcd_seq.sv
// Sequential double-dabble, one bit per cycle, MSB first.
// start/bin in; busy, done (final cycle), bcd (valid with done).
module bin2bcd_seq #(
  parameter int DATA_W = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     adj;

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // bcd is the accumulator after this cycle's shift;
  // the parent captures it when done is high
  assign bcd  = {adj[BW-2:0], sh[DATA_W-1]};
  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      acc  <= '0;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
        sh   <= bin;
        acc  <= '0;
      end
    end else begin
      acc <= bcd;
      sh  <= sh << 1;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seg7_hc595_driver.sv
// Sample -> BCD -> multiplexed 7-seg via two 74HC595 chains.
// clk, rst_n; in_if (value_i/valid/ready); seg_*/com_* pins.
// Build option SEG7_LZB_EN: leading-zero blanking.
module seg7_hc595_driver
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int DIGITS      = 4,
  parameter int SHIFT_DIV   = 4,
  parameter int REFRESH_DIV = 2700
) (
  input  logic clk,
  input  logic rst_n,
  seg7_hc595_driver_if.slave in_if,
  output logic seg_ser,
  output logic seg_srclk,
  output logic seg_rclk,
  output logic seg_oe_n,
  output logic com_ser,
  output logic com_srclk,
  output logic com_rclk,
  output logic com_oe_n
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WAIT_LEN = REFRESH_DIV - 1 - 17 * SHIFT_DIV;
  localparam logic [CW-1:0] WAIT_END = CW'(WAIT_LEN - 1);
  localparam logic [CW-1:0] HALF_END = CW'(SHIFT_DIV - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(2 * SHIFT_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam longint MAX_BIN = (longint'(1) << DATA_W) - 1;
  localparam longint MAX_BCD = pow10(DIGITS) - 1;

  if (MAX_BIN > MAX_BCD) begin : g_bad_width
    $error("DATA_W does not fit in DIGITS");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("DIGITS must be 1..8");
  end
  if (SHIFT_DIV < 1) begin : g_bad_sdiv
    $error("SHIFT_DIV must be >= 1");
  end
  if (REFRESH_DIV < 18 * SHIFT_DIV + 2) begin : g_bad_rdiv
    $error("REFRESH_DIV too small");
  end

  logic          conv_busy;
  logic          conv_done;
  logic [BW-1:0] conv_bcd;
  logic [BW-1:0] disp;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (in_if.value_valid && !conv_busy),
    .bin   (in_if.value_i),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign in_if.value_ready = !conv_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         disp <= '0;
    else if (conv_done) disp <= conv_bcd;
  end

  scan_state_t    st, st_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_q, bit_n;
  logic [IW-1:0]  idx, idx_n;
  logic [7:0]     seg_sh, seg_sh_n;
  logic [7:0]     com_sh, com_sh_n;
  logic           srclk_q, srclk_n;
  logic           rclk_q, rclk_n;
  logic           oe_q, oe_d;

  logic [3:0]     nib;
  logic [7:0]     seg_byte;
  logic [7:0]     com_byte;

  assign nib      = disp[{idx, 2'b00} +: 4];
  assign com_byte = ~(8'd1 << idx);

`ifdef SEG7_LZB_EN
  logic [BW-1:0] upper;
  assign upper    = disp >> {idx, 2'b00};
  assign seg_byte = (idx != '0 && upper == '0)
                  ? SEG_BLANK : decode(nib);
`else
  assign seg_byte = decode(nib);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= WAIT;
      cnt     <= '0;
      bit_q   <= '0;
      idx     <= '0;
      seg_sh  <= '0;
      com_sh  <= '0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      oe_q    <= 1'b1;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      bit_q   <= bit_n;
      idx     <= idx_n;
      seg_sh  <= seg_sh_n;
      com_sh  <= com_sh_n;
      srclk_q <= srclk_n;
      rclk_q  <= rclk_n;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    bit_n    = bit_q;
    idx_n    = idx;
    seg_sh_n = seg_sh;
    com_sh_n = com_sh;
    srclk_n  = srclk_q;
    rclk_n   = rclk_q;
    oe_d     = oe_q;
    unique case (st)
      WAIT: begin
        if (cnt == WAIT_END) begin
          st_n  = LOAD;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOAD: begin
        // frame snapshot: later BCD writes wait for next LOAD
        seg_sh_n = seg_byte;
        com_sh_n = com_byte;
        bit_n    = '0;
        cnt_n    = '0;
        srclk_n  = 1'b0;
        st_n     = SHIFT;
      end
      SHIFT: begin
        if (cnt == BIT_END) begin
          // zeros shift in, so ser rests low after bit 8
          cnt_n    = '0;
          srclk_n  = 1'b0;
          seg_sh_n = {seg_sh[6:0], 1'b0};
          com_sh_n = {com_sh[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            st_n   = LATCH;
            rclk_n = 1'b1;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          cnt_n   = cnt + 1'b1;
          srclk_n = (cnt >= HALF_END);
        end
      end
      LATCH: begin
        if (cnt == HALF_END) begin
          st_n   = WAIT;
          cnt_n  = '0;
          rclk_n = 1'b0;
          oe_d   = 1'b0;
          idx_n  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  assign seg_ser   = seg_sh[7];
  assign com_ser   = com_sh[7];
  assign seg_srclk = srclk_q;
  assign com_srclk = srclk_q;
  assign seg_rclk  = rclk_q;
  assign com_rclk  = rclk_q;
  assign seg_oe_n  = oe_q;
  assign com_oe_n  = oe_q;
endmodule
